// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS unified-memory arbiter.
// Request capture layout, FSM states and owner tags.
package mem_arb_pkg;

  localparam int MA_ADDR_W = 32;
  localparam int MA_DATA_W = 32;
  localparam int MA_BE_W   = MA_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  typedef struct packed {
    logic [MA_ADDR_W-1:0] addr;
    logic                 we;
    logic [MA_BE_W-1:0]   be;
    logic [MA_DATA_W-1:0] wdata;
  } mem_req_t;

  // Fetches are always full-word reads.
  function automatic mem_req_t if_capture(
    input logic [MA_ADDR_W-1:0] addr
  );
    mem_req_t r;
    r.addr  = addr;
    r.we    = 1'b0;
    r.be    = '1;
    r.wdata = '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side (IF, LS) and memory-side bundle of the arbiter.
// slave = arbiter, master = core plus memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MA_ADDR_W,
  parameter int DATA_W = MA_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic                ls_req;
  logic                ls_we;
  logic [DATA_W/8-1:0] ls_be;
  logic [ADDR_W-1:0]   ls_addr;
  logic [DATA_W-1:0]   ls_wdata;
  logic                ls_gnt;
  logic                ls_rvalid;
  logic [DATA_W-1:0]   ls_rdata;
  logic                ls_err;

  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  logic stall_o;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rvalid, mem_rdata,
    output stall_o
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rvalid, mem_rdata,
    input  stall_o
  );

endinterface

// File: rtl/mem_arbiter_timeout_counter.sv
// 8-bit WAIT-cycle counter; expired flags the last allowed cycle.
// Cleared while issuing, counts while waiting.
module mem_arbiter_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store.
// One transaction in flight, LS wins ties, WAIT bounded by TIMEOUT.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  owner_t     r_owner;
  owner_t     w_owner_nxt;
  mem_req_t   r_cap;
  mem_req_t   w_cap_nxt;

  logic                 r_err;
  logic [MA_DATA_W-1:0] r_if_rdata;
  logic [MA_DATA_W-1:0] r_ls_rdata;

  logic                 w_ls_sel;
  logic                 w_if_sel;
  logic                 w_if_gnt;
  logic                 w_ls_gnt;
  logic                 w_cnt_clr;
  logic                 w_cnt_en;
  logic                 w_expired;
  logic                 w_load;
  logic                 w_err;
  logic [MA_DATA_W-1:0] w_rdata;
  logic                 w_resp;

  // Reset gates the grant so every output reads 0 while held.
  assign w_ls_sel = reset & bus.ls_req;
  assign w_if_sel = reset & bus.if_req & ~bus.ls_req;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cap_nxt   = r_cap;
    w_if_gnt    = 1'b0;
    w_ls_gnt    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        unique case (1'b1)
          w_ls_sel: begin
            w_ls_gnt        = 1'b1;
            w_owner_nxt     = OWN_LS;
            w_cap_nxt.addr  = bus.ls_addr;
            w_cap_nxt.we    = bus.ls_we;
            w_cap_nxt.be    = bus.ls_be;
            w_cap_nxt.wdata = bus.ls_wdata;
            w_state_nxt     = ISSUE;
          end
          w_if_sel: begin
            w_if_gnt    = 1'b1;
            w_owner_nxt = OWN_IF;
            w_cap_nxt   = if_capture(bus.if_addr);
            w_state_nxt = ISSUE;
          end
          default: ;
        endcase
      end
      ISSUE: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_cnt_en = 1'b1;
        if (bus.mem_rvalid) begin
          w_load      = 1'b1;
          w_state_nxt = RESP;
        end else if (w_expired) begin
          w_load      = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_rdata = w_err ? '0 : bus.mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IF;
      r_cap      <= '0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cap   <= w_cap_nxt;
      if (w_load) begin
        r_err <= w_err;
        if (r_owner == OWN_LS) begin
          r_ls_rdata <= w_rdata;
        end else begin
          r_if_rdata <= w_rdata;
        end
      end
    end
  end

  mem_arbiter_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  assign w_resp = (r_state == RESP);

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.if_rvalid = w_resp & (r_owner == OWN_IF);
  assign bus.ls_rvalid = w_resp & (r_owner == OWN_LS);
  assign bus.if_err    = bus.if_rvalid & r_err;
  assign bus.ls_err    = bus.ls_rvalid & r_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rdata  = r_ls_rdata;

  assign bus.mem_req   = (r_state == ISSUE);
  assign bus.mem_we    = r_cap.we;
  assign bus.mem_be    = r_cap.be;
  assign bus.mem_addr  = r_cap.addr;
  assign bus.mem_wdata = r_cap.wdata;

  assign bus.stall_o = (r_state != IDLE)
                     | (reset & bus.if_req & bus.ls_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus
// random IF/LS traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int TO = 16;

  typedef struct {
    bit          ls;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          k;
    logic [31:0] data;
    int          g;
  } plan_t;

  typedef struct {
    bit          ls;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   in_flight = 1'b0;
  int   spur_req = 0;
  int   spur_done = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;

  plan_t plan_q[$];
  exp_t  sb[$];

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err,
             bus.ls_gnt, bus.ls_rvalid, bus.ls_rdata, bus.ls_err,
             bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr,
             bus.mem_wdata, bus.stall_o}, '0);
  endtask

  // Memory model: acks WAIT cycle k, never acks when k > TO.
  initial begin
    plan_t p;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset && spur_req != spur_done) begin
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        spur_done++;
      end else if (reset && bus.mem_req) begin
        if (plan_q.size() == 0) begin
          chk("mem_req_unexpected", 1, 0);
        end else begin
          p = plan_q.pop_front();
          chk("mem_req_cycle", cyc, p.g + 1);
          chk("mem_addr", bus.mem_addr, p.addr);
          chk("mem_we", bus.mem_we, p.we);
          chk("mem_be", bus.mem_be, p.be);
          if (p.ls) chk("mem_wdata", bus.mem_wdata, p.wdata);
          if (p.k <= TO) begin
            for (int i = 1; i < p.k; i++) begin
              @(negedge clk);
              chk("mem_req_wait", bus.mem_req, 0);
              chk("mem_addr_hold", bus.mem_addr, p.addr);
            end
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = p.data;
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
          end
        end
      end
    end
  end

  // Monitor: grant legality, stall, and response scoreboard.
  initial begin
    exp_t e;
    bit   g_any;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_flight = 1'b0;
        last_if   = '0;
        last_ls   = '0;
      end else begin
        chk("stall", bus.stall_o,
            in_flight | (bus.if_req & bus.ls_req));
        chk("gnt", {bus.if_gnt, bus.ls_gnt},
            {!in_flight & bus.if_req & !bus.ls_req,
             !in_flight & bus.ls_req});
        g_any = bus.if_gnt | bus.ls_gnt;
        if (bus.if_rvalid | bus.ls_rvalid) begin
          if (sb.size() == 0) begin
            chk("rvalid_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("rvalid_port", {bus.if_rvalid, bus.ls_rvalid},
                e.ls ? 2'b01 : 2'b10);
            chk("resp_cycle", cyc, e.due);
            if (e.ls) begin
              last_ls = e.data;
              chk("ls_err", bus.ls_err, e.err);
            end else begin
              last_if = e.data;
              chk("if_err", bus.if_err, e.err);
            end
          end
          in_flight = 1'b0;
        end else begin
          chk("err_idle", {bus.if_err, bus.ls_err}, 0);
        end
        chk("if_rdata", bus.if_rdata, last_if);
        chk("ls_rdata", bus.ls_rdata, last_ls);
        if (g_any) in_flight = 1'b1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the grant.
  task automatic issue(input bit ls, input logic [31:0] addr,
                       input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input int k,
                       input logic [31:0] data, input int dly,
                       input bit drop, output int g);
    plan_t p;
    exp_t  e;
    bit    got;
    repeat (dly) begin
      @(posedge clk); #1;
    end
    if (ls) begin
      bus.ls_req   = 1'b1;
      bus.ls_addr  = addr;
      bus.ls_we    = we;
      bus.ls_be    = be;
      bus.ls_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    got = 1'b0;
    g   = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ls ? bus.ls_gnt : bus.if_gnt) begin
        got = 1'b1;
        g   = cyc;
      end
    end
    chk(ls ? "ls_gnt_bound" : "if_gnt_bound", got, 1);
    if (got) begin
      p.ls    = ls;
      p.addr  = addr;
      p.we    = ls ? we : 1'b0;
      p.be    = ls ? be : 4'hF;
      p.wdata = wdata;
      p.k     = k;
      p.data  = data;
      p.g     = g;
      plan_q.push_back(p);
      if (!drop) begin
        e.ls  = ls;
        e.err = (k > TO);
        e.data = e.err ? 32'h0 : data;
        e.due = g + 2 + ((k > TO) ? TO : k);
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (ls) begin
      bus.ls_req   = 1'b0;
      bus.ls_addr  = $urandom;
      bus.ls_we    = 1'($urandom);
      bus.ls_be    = 4'($urandom);
      bus.ls_wdata = $urandom;
    end else begin
      bus.if_req  = 1'b0;
      bus.if_addr = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || in_flight) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int g_ls, g_if, mode, k1, k2;
    reset        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_be    = '0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_outputs");
    reset = 1'b1;
    @(posedge clk); #1;

    issue(0, 32'h10, 0, 0, 0, 2, 32'h0051_0093, 0, 0, g_if);
    drain();

    fork
      issue(1, 32'h100, 1, 4'b0011, 32'hDEAD_BEEF, 1,
            32'h1234_5678, 0, 0, g_ls);
      issue(0, 32'h40, 0, 0, 0, 3, 32'hCAFE_0001, 0, 0, g_if);
    join
    chk("if_gnt_after_resp", g_if, g_ls + 4);
    drain();

    issue(1, 32'h200, 0, 4'hF, 0, TO + 1, 32'h5555_AAAA, 0, 0, g_ls);
    issue(0, 32'h20, 0, 0, 0, 1, 32'h0000_0013, 0, 0, g_if);
    drain();

    issue(0, 32'h30, 0, 0, 0, TO, 32'hA5A5_0F0F, 0, 0, g_if);
    drain();

    issue(1, 32'h300, 0, 4'hF, 0, TO + 1, 32'h0, 0, 1, g_ls);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk_zero("reset_mid_wait");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    spur_req++;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("spur_after_reset", spur_done, spur_req);
    chk("stall_after_reset", bus.stall_o, 0);
    @(posedge clk); #1;

    spur_req++;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("spur_idle", spur_done, spur_req);
    chk("stall_idle", bus.stall_o, 0);
    @(posedge clk); #1;
    issue(0, 32'h44, 0, 0, 0, 1, 32'h0010_0073, 0, 0, g_if);
    drain();

    for (int it = 0; it < 80; it++) begin
      mode = $urandom_range(0, 2);
      k1   = $urandom_range(1, TO + 2);
      k2   = $urandom_range(1, TO + 2);
      if (mode == 0) begin
        issue(0, $urandom, 0, 0, 0, k1, $urandom, 0, 0, g_if);
      end else if (mode == 1) begin
        issue(1, $urandom, 1'($urandom), 4'($urandom), $urandom,
              k1, $urandom, 0, 0, g_ls);
      end else begin
        fork
          issue(1, $urandom, 1'($urandom), 4'($urandom), $urandom,
                k1, $urandom, $urandom_range(0, 3), 0, g_ls);
          issue(0, $urandom, 0, 0, 0, k2, $urandom,
                $urandom_range(0, 6), 0, g_if);
        join
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and the load/store unit (LS) of the RISC-V core.
- Captures one request at a time, issues it to memory and waits for the memory acknowledge.
- Routes the response back to the requester and stalls the core while a transaction is in flight.
- Bounds every transaction with a timeout counter so a dead memory cannot hang the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 16, maximum WAIT cycles before an error response; legal range 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request captured.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  DATA_W  fetched instruction.
- if_err  out  1  fetch timed out.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store.
- ls_be  in  DATA_W/8  byte enables.
- ls_addr  in  ADDR_W  data address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  load/store request captured.
- ls_rvalid  out  1  load/store response valid (loads and stores).
- ls_rdata  out  DATA_W  load data.
- ls_err  out  1  load/store timed out.
- mem_req  out  1  one-cycle request pulse to memory.
- mem_we  out  1  memory write.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rvalid  in  1  memory acknowledge, for both reads and writes.
- mem_rdata  in  DATA_W  memory read data.
- stall_o  out  1  core stall.

Behaviour:
- Reset value of every output is 0; FSM resets to IDLE.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrates combinationally with fixed priority LS > IF.
  - Winner's gnt is high this cycle.
  - Request fields (owner, addr, we, be, wdata) are registered.
  - Next state is ISSUE.
  - The loser sees gnt = 0 and must hold its req.
  - No requests: stay in IDLE.
- IF capture forces we = 0 and be = all ones.
- ISSUE: mem_req = 1 for exactly one cycle; mem_* driven from the captured registers; timeout counter cleared to 0; next state WAIT.
- WAIT:
  - mem_* fields are held stable and mem_req = 0.
  - Counter increments each cycle.
  - mem_rvalid = 1: register mem_rdata into the owner's rdata; next state RESP with err = 0.
  - Counter reaches TIMEOUT-1 without mem_rvalid: next state RESP with err = 1 and rdata = 0.
  - mem_rvalid and timeout in the same cycle: mem_rvalid wins (err = 0).
- RESP: the owner's rvalid (and err if set) is high for exactly one cycle; the other port's rvalid stays 0. Next state IDLE.
- rdata holds its value until the next response to that port.
- Latency with memory ack in cycle k of WAIT (k ≥ 1): gnt at cycle 0, mem_req at cycle 1, rvalid at cycle 2+k.
  - Minimum repeat interval is 4 cycles (gnt cycle, ISSUE, one WAIT cycle, RESP).
  - A new gnt is possible in the first IDLE cycle after RESP.
- stall_o = (state != IDLE) OR (if_req AND ls_req in IDLE).
- mem_rvalid seen in IDLE, ISSUE or RESP is spurious: ignored and never forwarded.
- Requests arriving outside IDLE are not granted; gnt stays 0.
- Reset asserted mid-transaction:
  - State goes to IDLE immediately and all outputs go to 0.
  - The outstanding transaction is dropped and never reported.
  - A late mem_rvalid after reset release is ignored as spurious.
- Store response: rvalid = 1 and rdata = mem_rdata (the core ignores rdata).

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum of arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - typedef enum of owner_t {OWN_IF, OWN_LS};
  - typedef struct mem_req_t {addr, we, be, wdata}, used for the capture register.
- Optional sub-module: timeout_counter (clear, enable, expired), 8-bit.
- Everything else stays in a single module.

Test Plan:
- Single IF read: if_req = 1, if_addr = 0x0000_0010; memory acks with 0x0051_0093 in the 2nd WAIT cycle → if_gnt at cycle 0, mem_req at cycle 1 with mem_we = 0 and mem_be = 4'hF, if_rvalid = 1 with if_rdata = 0x0051_0093 at cycle 4, ls_rvalid stays 0.
- Simultaneous requests: if_req and ls_req both high, ls_we = 1, ls_addr = 0x100, ls_be = 4'b0011, ls_wdata = 0xDEAD_BEEF → ls_gnt first and mem_* carries the store; if_gnt is asserted in the IDLE cycle after RESP; stall_o is high throughout.
- Timeout: ls_req load to 0x200 with mem_rvalid never asserted, TIMEOUT = 16 → ls_rvalid = 1, ls_err = 1, ls_rdata = 0 after 16 WAIT cycles; next IF request is serviced normally.
- Ack on the final WAIT cycle: mem_rvalid arrives in the same cycle the counter reaches TIMEOUT-1 → err = 0 and data forwarded.
- Reset mid-WAIT: pull reset low during WAIT, release, then pulse mem_rvalid → all outputs 0 during reset, no rvalid afterwards, FSM in IDLE.
- Spurious ack: mem_rvalid = 1 while IDLE with no requests → no rvalid on either port and no state change.
